// File: rtl/div_radix2.sv
// div_radix2: iterative restoring divider, one quotient bit per cycle, for DIV/DIVU.
// result_o = {remainder, quotient}; all outputs registered.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [WIDTH-1:0]   rem, rem_n, dvd, dvd_n, dsr, dsr_n;
    logic               sgn, sgn_n, s1, s1_n, s2, s2_n;
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   step_rem, step_dvd, a_mag, b_mag, q_fix, r_fix;

    // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
    assign diff     = {rem, dvd[WIDTH-1]} - {1'b0, dsr};
    assign step_rem = diff[WIDTH] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : diff[WIDTH-1:0];
    assign step_dvd = {dvd[WIDTH-2:0], ~diff[WIDTH]};
    assign a_mag    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign b_mag    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    assign q_fix    = (sgn && (s1 != s2)) ? -step_dvd : step_dvd;
    assign r_fix    = (sgn && s1) ? -step_rem : step_rem;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        dvd_n    = dvd;
        dsr_n    = dsr;
        sgn_n    = sgn;
        s1_n     = s1;
        s2_n     = s2;
        result_n = result_o;
        ready_n  = ready_o;
        case (state)
            IDLE: begin
                result_n = '0;
                ready_n  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = BY_ZERO;
                    end else begin
                        state_n = ON;
                        cnt_n   = '0;
                        rem_n   = '0;
                        dvd_n   = a_mag;
                        dsr_n   = b_mag;
                        sgn_n   = signed_div_i;
                        s1_n    = opdata1_i[WIDTH-1];
                        s2_n    = opdata2_i[WIDTH-1];
                    end
                end
            end
            BY_ZERO: begin
                state_n  = END;
                result_n = '0;
                ready_n  = 1'b1;
            end
            ON: begin
                if (annul_i || !start_i) begin
                    state_n  = IDLE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end else begin
                    rem_n = step_rem;
                    dvd_n = step_dvd;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state_n  = END;
                        result_n = {r_fix, q_fix};
                        ready_n  = 1'b1;
                    end
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    state_n  = IDLE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            sgn      <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            dvd      <= dvd_n;
            dsr      <= dsr_n;
            sgn      <= sgn_n;
            s1       <= s1_n;
            s2       <= s2_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end
endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: directed and random DIV/DIVU requests against an arithmetic model,
// with outputs compared on every falling edge.
module tb_div_radix2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    int          tests = 0;
    int          fails = 0;
    logic        exp_ready = 1'b0;
    logic [63:0] exp_res = '0;

    div_radix2 #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1),
        .opdata2_i(op2), .start_i(start), .annul_i(annul),
        .result_o(result), .ready_o(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 0) return 64'h0;
        if (!sd) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_ready", 64'(ready), 64'(exp_ready));
            chk("cyc_result", result, exp_ready ? exp_res : 64'h0);
        end
    end

    // ak: abort before edge ak of ON (0 = none); mode 0 annul, 1 start drop, 2 async reset
    task automatic run_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                           input int ak, input int mode, input int hold, input bit rend,
                           input bit has_lit, input logic [63:0] lit);
        logic [63:0] m;
        m = model(sd, a, b);
        signed_div = sd; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
        @(posedge clk); #1;
        op1 = $urandom; op2 = $urandom;
        if (b == 0) begin
            @(posedge clk); #1;
        end else begin
            for (int k = 1; k <= 32; k++) begin
                if (k == ak) begin
                    if (mode == 0) annul = 1'b1;
                    else if (mode == 1) start = 1'b0;
                    else begin
                        #2 rst = 1'b1;
                        #1 chk("rst_on_ready", 64'(ready), 64'h0);
                        chk("rst_on_result", result, 64'h0);
                        @(posedge clk); #1;
                        rst = 1'b0; start = 1'b0; annul = 1'b0;
                        return;
                    end
                end
                @(posedge clk); #1;
                op1 = $urandom; op2 = $urandom;
                if (k == ak) begin
                    annul = 1'b0; start = 1'b0;
                    return;
                end
            end
        end
        exp_ready = 1'b1;
        exp_res = m;
        if (has_lit) chk("literal", result, lit);
        if (rend) begin
            #2 rst = 1'b1;
            #1 chk("rst_end_ready", 64'(ready), 64'h0);
            chk("rst_end_result", result, 64'h0);
            exp_ready = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0; start = 1'b0;
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if ($urandom_range(0, 1) == 1) annul = 1'b1;
        else start = 1'b0;
        @(posedge clk); #1;
        exp_ready = 1'b0;
        annul = 1'b0; start = 1'b0;
        chk("drop", 64'(ready), 64'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk("reset_ready", 64'(ready), 64'h0);
        chk("reset_result", result, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_div(0, 32'd100, 32'd7, 0, 0, 0, 0, 1, {32'd2, 32'd14});
        run_div(1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div(1, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, 0, 1, {32'h1, 32'hFFFF_FFFD});
        run_div(0, 32'd1234, 32'd0, 0, 0, 0, 0, 1, 64'h0);
        run_div(1, 32'hFFFF_0000, 32'd0, 0, 0, 0, 0, 1, 64'h0);
        run_div(0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 1, {32'h0, 32'hFFFF_FFFF});
        run_div(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, {32'h0, 32'h8000_0000});
        run_div(0, 32'd1000, 32'd3, 10, 0, 0, 0, 0, 64'h0);
        run_div(0, 32'd9, 32'd3, 0, 0, 0, 0, 1, {32'h0, 32'h3});
        run_div(0, 32'd1000, 32'd3, 10, 1, 0, 0, 0, 64'h0);
        run_div(1, 32'd1000, 32'd3, 32, 0, 0, 0, 0, 64'h0);
        run_div(0, 32'd500, 32'd7, 10, 2, 0, 0, 0, 64'h0);
        run_div(0, 32'd50, 32'd5, 0, 0, 5, 0, 1, {32'h0, 32'd10});
        run_div(1, 32'hFFFF_FF9C, 32'd9, 0, 0, 0, 1, 1, {32'hFFFF_FFFF, 32'hFFFF_FFF5});
        start = 1'b1; annul = 1'b1; op1 = 32'd20; op2 = 32'd4;
        repeat (3) @(posedge clk);
        #1 start = 1'b0; annul = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            int ak, mode;
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            ak = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 32) : 0;
            mode = $urandom_range(0, 2);
            run_div($urandom_range(0, 1) == 1, a, b, ak, mode, $urandom_range(0, 3), 0, 0, 64'h0);
        end
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
